keccak_arb: RTL and testbench

KECCAK_ARB -- requirements
Module: keccak_arb

---
 rtl/keccak_arb.sv | 140 ++++++++++++++
 tb/tb_keccak_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keccak_arb.sv
// Two-requester round-robin front end for a keccak core: words pass straight through in STREAM (zero latency),
// the core's buffer_full backpressures the granted requester, and everyone else sees stall until re-arbitration.
module keccak_arb (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   rq_req,
  input  logic [1:0]   rq_valid,
  input  logic [63:0]  rq_data,
  input  logic [1:0]   rq_last,
  input  logic [3:0]   rq_byte_num,
  output logic [1:0]   rq_grant,
  output logic [1:0]   rq_stall,
  output logic [1:0]   rq_done,
  output logic [511:0] digest,
  output logic         core_reset,
  output logic [31:0]  core_in,
  output logic         core_in_ready,
  output logic         core_is_last,
  output logic [1:0]   core_byte_num,
  input  logic         core_buffer_full,
  input  logic [511:0] core_out,
  input  logic         core_out_ready
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic           gnt_q, gnt_d;
  logic           last_srv_q, last_srv_d;
  logic [7:0]     wdog_q, wdog_d;
  logic [511:0]   digest_q, digest_d;
  logic           crst_q, crst_d;

  logic [1:0]     gnt_oh;
  logic [31:0]    sel_data;
  logic [1:0]     sel_bn;
  logic           sel_valid;
  logic           sel_last;
  logic           sel_req;

  assign gnt_oh    = gnt_q ? 2'b10 : 2'b01;
  assign sel_data  = gnt_q ? rq_data[63:32] : rq_data[31:0];
  assign sel_bn    = gnt_q ? rq_byte_num[3:2] : rq_byte_num[1:0];
  assign sel_valid = rq_valid[gnt_q];
  assign sel_last  = rq_last[gnt_q];
  assign sel_req   = rq_req[gnt_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_srv_q <= 1'b1;
      wdog_q     <= 8'd0;
      digest_q   <= '0;
      crst_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_srv_q <= last_srv_d;
      wdog_q     <= wdog_d;
      digest_q   <= digest_d;
      crst_q     <= crst_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_srv_d    = last_srv_q;
    wdog_d        = 8'd0;
    digest_d      = digest_q;
    crst_d        = 1'b0;
    rq_grant      = 2'b00;
    rq_stall      = 2'b11;
    rq_done       = 2'b00;
    core_in       = 32'd0;
    core_in_ready = 1'b0;
    core_is_last  = 1'b0;
    core_byte_num = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (|rq_req) begin
          // On a tie the requester not served last wins.
          gnt_d   = (&rq_req) ? ~last_srv_q : rq_req[1];
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        rq_grant = gnt_oh;
        state_d  = S_STREAM;
      end
      S_STREAM: begin
        rq_grant          = gnt_oh;
        rq_stall[gnt_q]   = core_buffer_full;
        core_in           = sel_data;
        core_is_last      = sel_last;
        core_byte_num     = sel_bn;
        core_in_ready     = sel_valid & ~core_buffer_full;
        if (!sel_req) begin
          // Abandoned message: scrub the core on the way back to IDLE.
          crst_d  = 1'b1;
          state_d = S_IDLE;
        end else if (core_in_ready && sel_last) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        rq_grant = gnt_oh;
        if (core_out_ready) begin
          digest_d = core_out;
          state_d  = S_DONE;
        end else if (wdog_q == 8'd254) begin
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      S_DONE: begin
        rq_grant   = gnt_oh;
        rq_done    = gnt_oh;
        last_srv_d = gnt_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign core_reset = crst_q | (state_q == S_CLR);
  assign digest     = digest_q;

endmodule

// File: tb/tb_keccak_arb.sv
// Bench for keccak_arb: a toy order-sensitive core model, a scoreboard of expected (grant, digest) pairs,
// a table of whole messages, and hand-written tie / abort / watchdog / async-reset sequences.
module tb_keccak_arb;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   rq_req, rq_valid, rq_last;
  logic [63:0]  rq_data;
  logic [3:0]   rq_byte_num;
  logic [1:0]   rq_grant, rq_stall, rq_done;
  logic [511:0] digest;
  logic         core_reset;
  logic [31:0]  core_in;
  logic         core_in_ready, core_is_last;
  logic [1:0]   core_byte_num;
  logic         core_buffer_full;
  logic [511:0] core_out = '0;
  logic         core_out_ready = 1'b0;

  always #5 clk = ~clk;

  keccak_arb dut (
    .clk(clk), .reset_n(reset_n),
    .rq_req(rq_req), .rq_valid(rq_valid), .rq_data(rq_data), .rq_last(rq_last),
    .rq_byte_num(rq_byte_num), .rq_grant(rq_grant), .rq_stall(rq_stall), .rq_done(rq_done),
    .digest(digest), .core_reset(core_reset), .core_in(core_in), .core_in_ready(core_in_ready),
    .core_is_last(core_is_last), .core_byte_num(core_byte_num), .core_buffer_full(core_buffer_full),
    .core_out(core_out), .core_out_ready(core_out_ready)
  );

  int total = 0;
  int bad   = 0;

  // Toy hash standing in for the keccak core: rotation makes it sensitive to word order and duplication.
  function automatic logic [511:0] mix(input logic [511:0] s, input logic [31:0] w,
                                       input logic last, input logic [1:0] bn);
    logic [511:0] r;
    r = {s[474:0], s[511:475]};
    r[31:0] = r[31:0] ^ w;
    if (last) begin
      r[33:32] = r[33:32] ^ bn;
      r[34]    = ~r[34];
    end
    return r;
  endfunction

  function automatic logic [511:0] hash_msg(input logic [3:0][31:0] w, input int n, input logic [1:0] bn);
    logic [511:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = mix(s, w[i], (i == n - 1), bn);
    return s;
  endfunction

  logic         core_hold = 1'b0;
  logic [511:0] cst = '0;
  int           dly = 0;

  always @(posedge clk) begin
    if (core_reset) begin
      cst            <= '0;
      dly            <= 0;
      core_out_ready <= 1'b0;
      core_out       <= '0;
    end else if (core_in_ready) begin
      cst <= mix(cst, core_in, core_is_last, core_byte_num);
      if (core_is_last) dly <= 3;
    end else if (dly > 1) begin
      dly <= dly - 1;
    end else if (dly == 1 && !core_hold) begin
      core_out       <= cst;
      core_out_ready <= 1'b1;
      dly            <= 0;
    end
  end

  typedef struct {
    logic [1:0]   gnt;
    logic [511:0] dig;
  } exp_t;
  exp_t         sb[$];
  logic [511:0] last_dig = '0;

  typedef struct {
    int              id;
    int              n;
    logic [3:0][31:0] w;
    logic [1:0]      bn;
    int              stall_at;
    int              stall_len;
    logic [1:0]      exp_gnt;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_grant(input logic [1:0] exp_gnt);
    int k;
    k = 0;
    @(negedge clk);
    while (rq_grant == 2'b00 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("grant", rq_grant, exp_gnt);
    chk("clr_core_reset", core_reset, 1'b1);
    chk("clr_stall", rq_stall, 2'b11);
    chk("clr_in_ready", core_in_ready, 1'b0);
  endtask

  task automatic stream(input int id, input int n, input logic [3:0][31:0] w, input logic [1:0] bn,
                        input int stall_at, input int stall_len, input logic has_last);
    int   i;
    int   st;
    int   cyc;
    logic full;
    i = 0; st = 0; cyc = 0;
    while (i < n && cyc < 100) begin
      @(negedge clk);
      cyc++;
      full = (i == stall_at) && (st < stall_len);
      core_buffer_full              = full;
      rq_valid[id]                  = 1'b1;
      rq_data[id*32 +: 32]          = w[i];
      rq_last[id]                   = has_last && (i == n - 1);
      rq_byte_num[id*2 +: 2]        = bn;
      #1;
      if (cyc == 1) chk("stream_core_reset", core_reset, 1'b0);
      chk("in_ready", core_in_ready, !full);
      chk("stall_granted", rq_stall[id], full);
      chk("stall_other", rq_stall[1-id], 1'b1);
      if (!full) chk("core_in", core_in, w[i]);
      if (full) st++;
      else i++;
    end
    chk("stream_words", i, n);
    @(negedge clk);
    rq_valid         = 2'b00;
    rq_last          = 2'b00;
    core_buffer_full = 1'b0;
  endtask

  task automatic wait_done(input int id);
    exp_t e;
    int   k;
    k = 0;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_underflow: got empty queue want entry");
      return;
    end
    e = sb.pop_front();
    while (rq_done == 2'b00 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("done", rq_done, e.gnt);
    chk("digest", digest, e.dig);
    last_dig    = e.dig;
    rq_req[id]  = 1'b0;
    @(negedge clk);
    chk("done_pulse", rq_done, 2'b00);
    chk("idle_grant", rq_grant, 2'b00);
  endtask

  task automatic run_msg(input vec_t v);
    rq_req[v.id] = 1'b1;
    sb.push_back('{gnt: v.exp_gnt, dig: hash_msg(v.w, v.n, v.bn)});
    wait_grant(v.exp_gnt);
    stream(v.id, v.n, v.w, v.bn, v.stall_at, v.stall_len, 1'b1);
    chk("wait_grant_held", rq_grant, v.exp_gnt);
    chk("wait_stall", rq_stall, 2'b11);
    wait_done(v.id);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] hello;
    int               k;
    logic             seen;
    hello = {32'h0000_0000, 32'h646C_726F, 32'h7720_2C6F, 32'h6C6C_6548};
    tbl[0] = '{id: 0, n: 4, w: hello, bn: 2'd0, stall_at: -1, stall_len: 0, exp_gnt: 2'b01};
    tbl[1] = '{id: 1, n: 3, w: {32'h0, 32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_BEEF}, bn: 2'd2,
               stall_at: -1, stall_len: 0, exp_gnt: 2'b10};
    tbl[2] = '{id: 0, n: 4, w: hello, bn: 2'd0, stall_at: 2, stall_len: 3, exp_gnt: 2'b01};
    tbl[3] = '{id: 1, n: 1, w: {32'h0, 32'h0, 32'h0, 32'hA5A5_0001}, bn: 2'd3,
               stall_at: 0, stall_len: 3, exp_gnt: 2'b10};
    tbl[4] = '{id: 0, n: 2, w: {32'h0, 32'h0, 32'h0BAD_0002, 32'h7777_1111}, bn: 2'd1,
               stall_at: 1, stall_len: 1, exp_gnt: 2'b01};

    reset_n = 1'b1; rq_req = '0; rq_valid = '0; rq_data = '0; rq_last = '0;
    rq_byte_num = '0; core_buffer_full = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_core_reset", core_reset, 1'b1);
    chk("rst_grant", rq_grant, 2'b00);
    chk("rst_stall", rq_stall, 2'b11);
    chk("rst_done", rq_done, 2'b00);
    chk("rst_digest", digest, '0);
    chk("rst_in_ready", core_in_ready, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_release_core_reset", core_reset, 1'b0);

    // Two ties in a row: requester 0 wins each, requester 1 follows.
    for (int t = 0; t < 2; t++) begin
      rq_req = 2'b11;
      sb.push_back('{gnt: 2'b01, dig: hash_msg(tbl[0].w, 4, 2'd0)});
      sb.push_back('{gnt: 2'b10, dig: hash_msg(tbl[1].w, 3, 2'd2)});
      wait_grant(2'b01);
      stream(0, 4, tbl[0].w, 2'd0, -1, 0, 1'b1);
      wait_done(0);
      wait_grant(2'b10);
      stream(1, 3, tbl[1].w, 2'd2, -1, 0, 1'b1);
      wait_done(1);
    end

    for (int t = 0; t < 5; t++) run_msg(tbl[t]);

    // Requester 1 walks away after two words.
    rq_req[1] = 1'b1;
    wait_grant(2'b10);
    stream(1, 2, tbl[1].w, 2'd0, -1, 0, 1'b0);
    rq_req[1] = 1'b0;
    @(negedge clk);
    chk("abort_core_reset", core_reset, 1'b1);
    chk("abort_grant", rq_grant, 2'b00);
    chk("abort_done", rq_done, 2'b00);
    @(negedge clk);
    chk("abort_reset_pulse", core_reset, 1'b0);
    chk("abort_done2", rq_done, 2'b00);
    run_msg(tbl[0]);

    // Core never answers: watchdog must release the grant.
    core_hold = 1'b1;
    rq_req[0] = 1'b1;
    wait_grant(2'b01);
    stream(0, 3, tbl[1].w, 2'd1, -1, 0, 1'b1);
    k = 0; seen = 1'b0;
    while (rq_grant != 2'b00 && k < 400) begin
      if (rq_done != 2'b00) seen = 1'b1;
      k++;
      @(negedge clk);
    end
    rq_req[0] = 1'b0;
    total++;
    if (k < 255 || k > 256) begin
      bad++;
      $display("FAIL wd_cycles: got %0d want 255..256", k);
    end
    chk("wd_no_done", seen, 1'b0);
    chk("wd_digest", digest, last_dig);
    core_hold = 1'b0;
    @(negedge clk);

    // Asynchronous reset between edges in the middle of a message.
    rq_req[0] = 1'b1;
    wait_grant(2'b01);
    @(negedge clk);
    core_buffer_full = 1'b1;
    rq_valid[0] = 1'b1; rq_data[31:0] = 32'hFFFF_FFFF; rq_last[0] = 1'b1; rq_byte_num[1:0] = 2'd3;
    #1;
    chk("pre_rst_stall", rq_stall, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_core_reset", core_reset, 1'b1);
    chk("arst_grant", rq_grant, 2'b00);
    chk("arst_stall", rq_stall, 2'b11);
    chk("arst_done", rq_done, 2'b00);
    chk("arst_digest", digest, '0);
    chk("arst_in_ready", core_in_ready, 1'b0);
    chk("arst_is_last", core_is_last, 1'b0);
    chk("arst_core_in", core_in, 32'd0);
    chk("arst_byte_num", core_byte_num, 2'd0);
    @(negedge clk);
    rq_req = '0; rq_valid = '0; rq_last = '0; core_buffer_full = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("arst_release_core_reset", core_reset, 1'b0);
    chk("arst_release_done", rq_done, 2'b00);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
